// File: rtl/ddp_pkt_pkg.sv
// ddp_pkt_pkg: packet layouts and constants shared by the data-driven
// pipeline stages.
//   op_pkt_t   : 38-bit operand packet  {GEN, DEST, LR, SGL, DATA}
//   fire_pkt_t : 55-bit firing packet   {GEN, DEST, SGL, LDATA, RDATA}
//   mem_payload_t : matching-memory word without its valid bit
//   match_state_e : matching-stage FSM encoding
package ddp_pkt_pkg;

  localparam int GEN_W       = 11;
  localparam int DEST_W      = 7;
  localparam int DATA_W      = 18;
  localparam int IN_W        = 38;
  localparam int OUT_W       = 55;
  localparam int MATCH_DEPTH = 128;
  // Stored word is V + GEN + LR + DATA.
  localparam int ENTRY_W     = 1 + GEN_W + 1 + DATA_W;

  // Operand packet bit positions: GEN[37:27] DEST[26:20] LR[19] SGL[18] DATA[17:0]
  typedef struct packed {
    logic [GEN_W-1:0]  gen;
    logic [DEST_W-1:0] dest;
    logic              lr;
    logic              sgl;
    logic [DATA_W-1:0] data;
  } op_pkt_t;

  // Firing packet bit positions: GEN[54:44] DEST[43:37] SGL[36] LDATA[35:18] RDATA[17:0]
  typedef struct packed {
    logic [GEN_W-1:0]  gen;
    logic [DEST_W-1:0] dest;
    logic              sgl;
    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] rdata;
  } fire_pkt_t;

  typedef struct packed {
    logic [GEN_W-1:0]  gen;
    logic              lr;
    logic [DATA_W-1:0] data;
  } mem_payload_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } match_state_e;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_STORE = 2'd1,
    ACT_FIRE  = 2'd2,
    ACT_DROP  = 2'd3
  } match_act_e;

endpackage

// File: rtl/match_mem.sv
// match_mem: direct-mapped 128-entry matching store.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all V)
//   rd_addr             : combinational read index (DEST)
//   rd_valid, rd_data   : V bit and payload of the addressed entry
//   wr_en/wr_addr/wr_data : synchronous write, sets V
//   clr_en/clr_addr     : synchronous clear of one V bit
// Only the V bits are reset; payloads are don't-care while V=0.
module match_mem
  import ddp_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DEST_W-1:0] rd_addr,
  output logic              rd_valid,
  output mem_payload_t      rd_data,
  input  logic              wr_en,
  input  logic [DEST_W-1:0] wr_addr,
  input  mem_payload_t      wr_data,
  input  logic              clr_en,
  input  logic [DEST_W-1:0] clr_addr
);

  logic [MATCH_DEPTH-1:0] v_q;
  logic [MATCH_DEPTH-1:0] v_d;
  mem_payload_t           payload_q [MATCH_DEPTH];

  always_comb begin
    v_d = v_q;
    if (clr_en) v_d[clr_addr] = 1'b0;
    if (wr_en)  v_d[wr_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) payload_q[wr_addr] <= wr_data;
  end

  assign rd_valid = v_q[rd_addr];
  assign rd_data  = payload_q[rd_addr];

endmodule

// File: rtl/match_stage.sv
// match_stage: joins left/right operand packets with equal DEST and GEN into
// one firing packet; single-operand packets pass straight through.
//   CP, MR_N               : clock, asynchronous active-low master reset
//   Send_in/Ack_out/PACKET_IN  : upstream channel, 38-bit operand packets
//   Send_out/Ack_in/PACKET_OUT : downstream channel, 55-bit firing packets
//   COLL                   : one-cycle pulse per dropped (colliding) packet
//   COLL_CNT               : saturating drop count, only with MATCH_COLL_CNT_EN
// Handshake: a transfer happens on a rising CP edge where valid (Send_*) and
// ready (Ack_*) are both 1; a held valid keeps its payload stable until then.
// Optional build macro: MATCH_COLL_CNT_EN.
module match_stage
  import ddp_pkt_pkg::*;
(
  input  logic             CP,
  input  logic             MR_N,
  input  logic             Send_in,
  output logic             Ack_out,
  input  logic [IN_W-1:0]  PACKET_IN,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic [OUT_W-1:0] PACKET_OUT,
  output logic             COLL
`ifdef MATCH_COLL_CNT_EN
  ,
  output logic [15:0]      COLL_CNT
`endif
);

  match_state_e state_q, state_d;
  op_pkt_t      dl_q, dl_d;
  fire_pkt_t    pkt_out_q, pkt_out_d;
  logic         send_out_q, send_out_d;
  logic         coll_q, coll_d;

  logic         ent_v;
  mem_payload_t ent;
  logic         wr_en, clr_en;
  mem_payload_t wr_data;
  match_act_e   act;
  logic         out_free;
  fire_pkt_t    pass_pkt, fire_pkt;

  match_mem u_mem (
    .clk      (CP),
    .rst_n    (MR_N),
    .rd_addr  (dl_q.dest),
    .rd_valid (ent_v),
    .rd_data  (ent),
    .wr_en    (wr_en),
    .wr_addr  (dl_q.dest),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_addr (dl_q.dest)
  );

  always_comb begin
    if (dl_q.sgl)                                       act = ACT_PASS;
    else if (!ent_v)                                    act = ACT_STORE;
    else if (ent.gen == dl_q.gen && ent.lr != dl_q.lr)  act = ACT_FIRE;
    else                                                act = ACT_DROP;

    // The output register can take a new packet if empty or draining this edge.
    out_free = !send_out_q || Ack_in;

    pass_pkt = '{gen: dl_q.gen, dest: dl_q.dest, sgl: 1'b1,
                 ldata: dl_q.data, rdata: '0};
    fire_pkt = '{gen: dl_q.gen, dest: dl_q.dest, sgl: 1'b0,
                 ldata: dl_q.lr ? ent.data  : dl_q.data,
                 rdata: dl_q.lr ? dl_q.data : ent.data};
    wr_data  = '{gen: dl_q.gen, lr: dl_q.lr, data: dl_q.data};

    state_d    = state_q;
    dl_d       = dl_q;
    pkt_out_d  = pkt_out_q;
    send_out_d = send_out_q && !Ack_in;
    coll_d     = 1'b0;
    wr_en      = 1'b0;
    clr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Send_in) begin
          dl_d    = op_pkt_t'(PACKET_IN);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        case (act)
          ACT_PASS: begin
            if (out_free) begin
              pkt_out_d  = pass_pkt;
              send_out_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
          ACT_STORE: begin
            wr_en   = 1'b1;
            state_d = ST_IDLE;
          end
          ACT_FIRE: begin
            // Memory clear is held back with the load so a stalled FIRE retries cleanly.
            if (out_free) begin
              pkt_out_d  = fire_pkt;
              send_out_d = 1'b1;
              clr_en     = 1'b1;
              state_d    = ST_IDLE;
            end
          end
          default: begin
            coll_d  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MATCH_COLL_CNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_d && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) coll_cnt_q <= '0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign COLL_CNT = coll_cnt_q;
`endif

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state_q    <= ST_IDLE;
      dl_q       <= '0;
      pkt_out_q  <= '0;
      send_out_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      pkt_out_q  <= pkt_out_d;
      send_out_q <= send_out_d;
      coll_q     <= coll_d;
    end
  end

  assign Ack_out    = (state_q == ST_IDLE);
  assign Send_out   = send_out_q;
  assign PACKET_OUT = pkt_out_q;
  assign COLL       = coll_q;

endmodule
